// File: rtl/display_pkg.sv
// Shared constants and pattern decoding for the multiplexed display capture block.
// Anode patterns are active-low one-hot; all-high means no digit is being driven.
package display_pkg;

    localparam logic [3:0] DIGIT0_PAT = 4'b1110;
    localparam logic [3:0] DIGIT1_PAT = 4'b1101;
    localparam logic [3:0] DIGIT2_PAT = 4'b1011;
    localparam logic [3:0] DIGIT3_PAT = 4'b0111;
    localparam logic [3:0] BLANK_PAT  = 4'b1111;

    localparam int DEFAULT_STABLE_CYCLES  = 1;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef enum logic [1:0] {
        PAT_BLANK,
        PAT_DIGIT,
        PAT_ILLEGAL
    } pat_kind_e;

    typedef struct packed {
        pat_kind_e  kind;
        logic [1:0] index;
    } pat_decode_t;

    function automatic pat_decode_t decode_select(input logic [3:0] sel);
        pat_decode_t d;
        d.kind  = PAT_ILLEGAL;
        d.index = 2'd0;
        case (sel)
            DIGIT0_PAT: begin d.kind = PAT_DIGIT; d.index = 2'd0; end
            DIGIT1_PAT: begin d.kind = PAT_DIGIT; d.index = 2'd1; end
            DIGIT2_PAT: begin d.kind = PAT_DIGIT; d.index = 2'd2; end
            DIGIT3_PAT: begin d.kind = PAT_DIGIT; d.index = 2'd3; end
            BLANK_PAT:  d.kind = PAT_BLANK;
            default:    d.kind = PAT_ILLEGAL;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/display_capture_if.sv
// Scan-bus inputs and reconstructed-frame outputs of display_capture.
// The master side drives the scan bus; the slave side is the capture block.
interface display_capture_if;

    logic [3:0]  digit_select;
    logic [3:0]  digit_value;
    logic        err_clear;
    logic [15:0] frame_word;
    logic        frame_valid;
    logic [3:0]  digit_seen;
    logic        err_flag;
    logic        scan_lost;

    modport master (
        output digit_select, digit_value, err_clear,
        input  frame_word, frame_valid, digit_seen, err_flag, scan_lost
    );

    modport slave (
        input  digit_select, digit_value, err_clear,
        output frame_word, frame_valid, digit_seen, err_flag, scan_lost
    );

endinterface

// File: rtl/dwell_filter.sv
// Samples the scan bus once and accepts a digit after it has held steady for
// STABLE_CYCLES sampled cycles; accept/index/nibble/illegal are combinational.
module dwell_filter
    import display_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit_select,
    input  logic [3:0] digit_value,
    output logic       accept,
    output logic [1:0] digit_index,
    output logic [3:0] digit_nibble,
    output logic       illegal
);

    localparam logic [3:0] STABLE_LIMIT = 4'(STABLE_CYCLES);

    logic [3:0]  sel_reg;
    logic [3:0]  val_reg;
    logic [3:0]  prev_sel_reg;
    logic [3:0]  prev_val_reg;
    logic [3:0]  dwell_reg;
    logic [3:0]  dwell_next;
    logic        changed;
    pat_decode_t dec;

    always_comb begin
        dec        = decode_select(sel_reg);
        changed    = (sel_reg != prev_sel_reg) || (val_reg != prev_val_reg);
        dwell_next = 4'd0;
        if (dec.kind == PAT_DIGIT) begin
            if (changed)
                dwell_next = 4'd1;
            else if (dwell_reg != 4'd15)
                dwell_next = dwell_reg + 4'd1;
            else
                dwell_next = dwell_reg;
        end
    end

    // A saturated count that stays put must not re-trigger acceptance.
    assign accept       = (dec.kind == PAT_DIGIT) && (dwell_next == STABLE_LIMIT) &&
                          (changed || (dwell_reg != dwell_next));
    assign digit_index  = dec.index;
    assign digit_nibble = val_reg;
    assign illegal      = (dec.kind == PAT_ILLEGAL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_reg      <= BLANK_PAT;
            val_reg      <= 4'd0;
            prev_sel_reg <= BLANK_PAT;
            prev_val_reg <= 4'd0;
            dwell_reg    <= 4'd0;
        end else begin
            sel_reg      <= digit_select;
            val_reg      <= digit_value;
            prev_sel_reg <= sel_reg;
            prev_val_reg <= val_reg;
            dwell_reg    <= dwell_next;
        end
    end

endmodule

// File: rtl/display_capture.sv
// Rebuilds a 16-bit word from a four-digit multiplexed display scan bus,
// flagging illegal anode patterns and loss of scanning activity.
module display_capture
    import display_pkg::*;
#(
    parameter int STABLE_CYCLES  = DEFAULT_STABLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    display_capture_if.slave bus
);

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic        accept;
    logic        illegal;
    logic [1:0]  digit_index;
    logic [3:0]  digit_nibble;
    logic [15:0] frame_next;
    logic [3:0]  seen_next;
    logic        timeout_hit;

    logic [15:0] frame_word_reg;
    logic        frame_valid_reg;
    logic [3:0]  digit_seen_reg;
    logic        err_flag_reg;
    logic        scan_lost_reg;
    logic [15:0] timeout_reg;

    dwell_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_dwell (
        .clk         (clk),
        .reset       (reset),
        .digit_select(bus.digit_select),
        .digit_value (bus.digit_value),
        .accept      (accept),
        .digit_index (digit_index),
        .digit_nibble(digit_nibble),
        .illegal     (illegal)
    );

    // Per-digit shadow nibbles; frame_next already includes the nibble accepted this edge.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            logic       hit;
            logic [3:0] shadow_reg;

            assign hit = accept && (digit_index == 2'(gi));

            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    shadow_reg <= 4'd0;
                else if (hit)
                    shadow_reg <= digit_nibble;
            end

            assign frame_next[gi*4 +: 4] = hit ? digit_nibble : shadow_reg;
            assign seen_next[gi]         = digit_seen_reg[gi] | hit;
        end
    endgenerate

    assign timeout_hit = !accept && (timeout_reg == TIMEOUT_LIMIT - 16'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_word_reg  <= 16'd0;
            frame_valid_reg <= 1'b0;
            digit_seen_reg  <= 4'd0;
            err_flag_reg    <= 1'b0;
            scan_lost_reg   <= 1'b0;
            timeout_reg     <= 16'd0;
        end else begin
            frame_valid_reg <= 1'b0;

            // An illegal pattern wins over a simultaneous clear request.
            if (illegal)
                err_flag_reg <= 1'b1;
            else if (bus.err_clear)
                err_flag_reg <= 1'b0;

            if (accept) begin
                timeout_reg   <= 16'd0;
                scan_lost_reg <= 1'b0;
                if (&seen_next) begin
                    frame_word_reg  <= frame_next;
                    frame_valid_reg <= 1'b1;
                    digit_seen_reg  <= 4'd0;
                end else begin
                    digit_seen_reg <= seen_next;
                end
            end else begin
                if (timeout_reg != TIMEOUT_LIMIT)
                    timeout_reg <= timeout_reg + 16'd1;
                if (timeout_hit)
                    scan_lost_reg <= 1'b1;
                if (illegal || timeout_hit)
                    digit_seen_reg <= 4'd0;
            end
        end
    end

    assign bus.frame_word  = frame_word_reg;
    assign bus.frame_valid = frame_valid_reg;
    assign bus.digit_seen  = digit_seen_reg;
    assign bus.err_flag    = err_flag_reg;
    assign bus.scan_lost   = scan_lost_reg;

endmodule

// File: tb/tb_display_capture.sv
// Scoreboard bench: two capture instances (dwell 1 and 3) share one scan bus;
// a pattern-history reference model predicts status and frames per clock edge.
module tb_display_capture;

    localparam int TMO = 16;

    typedef struct {
        int          tag;
        logic [3:0]  seen;
        logic        err;
        logic        lost;
        logic [15:0] word;
    } status_t;

    typedef struct {
        int          tag;
        logic [15:0] word;
    } frame_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    display_capture_if bus_a ();
    display_capture_if bus_b ();

    display_capture #(.STABLE_CYCLES(1), .TIMEOUT_CYCLES(TMO)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    display_capture #(.STABLE_CYCLES(3), .TIMEOUT_CYCLES(TMO)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    // Reference model state, one slot per instance.
    int          stable_of [2] = '{1, 3};
    logic [3:0]  m_seen    [2];
    logic        m_err     [2];
    logic        m_lost    [2];
    logic [15:0] m_word    [2];
    logic [3:0]  m_shadow  [2][4];
    int          m_idle    [2];
    logic [7:0]  m_hist    [2][$];
    status_t     st_q      [2][$];
    frame_t      fr_q      [2][$];
    int          fv_count  [2] = '{0, 0};
    logic [3:0]  prev_sel = 4'hF;
    logic [3:0]  prev_val = 4'h0;

    function automatic void chk(input string name, input int i, input logic [15:0] got,
                                input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, i, cyc, got, exp);
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_seen[i] = 0; m_err[i] = 0; m_lost[i] = 0; m_word[i] = 0; m_idle[i] = 0;
            for (int d = 0; d < 4; d++) m_shadow[i][d] = 0;
            m_hist[i].delete(); st_q[i].delete(); fr_q[i].delete();
        end
    endtask

    // Predict the state after edge 'tag', whose decision sees pattern sel/val.
    task automatic model_step(input int i, input logic [3:0] sel, input logic [3:0] val,
                              input logic clr, input int tag);
        logic [3:0] low_bit;
        int idx, run;
        bit is_digit, blank, illegal, accept;
        status_t s;
        frame_t f;
        is_digit = 0; idx = 0;
        for (int d = 0; d < 4; d++) begin
            low_bit = 4'b0001 << d;
            if (sel == ~low_bit) begin is_digit = 1; idx = d; end
        end
        blank   = (sel == 4'hF);
        illegal = !blank && !is_digit;
        m_hist[i].push_back({sel, val});
        if (m_hist[i].size() > 17) void'(m_hist[i].pop_front());
        run = 0;
        if (is_digit)
            for (int j = m_hist[i].size() - 1; j >= 0; j--) begin
                if (m_hist[i][j] != {sel, val}) break;
                run++;
            end
        accept = is_digit && (run == stable_of[i]);
        if (illegal) m_err[i] = 1;
        else if (clr) m_err[i] = 0;
        if (accept) begin
            m_shadow[i][idx] = val;
            m_seen[i][idx]   = 1'b1;
            m_idle[i] = 0;
            m_lost[i] = 0;
            if (m_seen[i] == 4'hF) begin
                m_word[i] = {m_shadow[i][3], m_shadow[i][2], m_shadow[i][1], m_shadow[i][0]};
                f.tag = tag; f.word = m_word[i];
                fr_q[i].push_back(f);
                m_seen[i] = 0;
            end
        end else begin
            if (m_idle[i] < TMO) begin
                m_idle[i]++;
                if (m_idle[i] == TMO) begin m_lost[i] = 1; m_seen[i] = 0; end
            end
            if (illegal) m_seen[i] = 0;
        end
        s.tag = tag; s.seen = m_seen[i]; s.err = m_err[i]; s.lost = m_lost[i]; s.word = m_word[i];
        st_q[i].push_back(s);
    endtask

    task automatic set_pins(input logic [3:0] sel, input logic [3:0] val, input logic clr);
        bus_a.digit_select = sel; bus_a.digit_value = val; bus_a.err_clear = clr;
        bus_b.digit_select = sel; bus_b.digit_value = val; bus_b.err_clear = clr;
    endtask

    // Called just after a falling edge; returns after the next falling edge.
    task automatic drive(input logic [3:0] sel, input logic [3:0] val, input logic clr);
        set_pins(sel, val, clr);
        for (int i = 0; i < 2; i++) model_step(i, prev_sel, prev_val, clr, cyc + 1);
        prev_sel = sel;
        prev_val = val;
        @(negedge clk);
    endtask

    task automatic blanks(input int n);
        repeat (n) drive(4'hF, 4'h0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        set_pins(4'hF, 4'h0, 1'b0);
        model_reset();
        repeat (n) @(negedge clk);
        reset    = 1'b0;
        prev_sel = 4'hF;
        prev_val = 4'h0;
    endtask

    task automatic grab(input int i, output logic [3:0] seen, output logic err,
                        output logic lost, output logic [15:0] word, output logic valid);
        if (i == 0) begin
            seen = bus_a.digit_seen; err = bus_a.err_flag; lost = bus_a.scan_lost;
            word = bus_a.frame_word; valid = bus_a.frame_valid;
        end else begin
            seen = bus_b.digit_seen; err = bus_b.err_flag; lost = bus_b.scan_lost;
            word = bus_b.frame_word; valid = bus_b.frame_valid;
        end
    endtask

    // Monitor: compares per-edge status and pops expected frames on frame_valid.
    initial begin
        logic [3:0]  seen;
        logic        err, lost, valid;
        logic [15:0] word;
        status_t     s;
        frame_t      f;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                grab(i, seen, err, lost, word, valid);
                if (reset) begin
                    chk("rst_word", i, word, 16'h0);
                    chk("rst_seen", i, 16'(seen), 16'h0);
                    chk("rst_flags", i, {13'd0, err, lost, valid}, 16'h0);
                end else begin
                    if (st_q[i].size() > 0 && st_q[i][0].tag == cyc) begin
                        s = st_q[i].pop_front();
                        chk("digit_seen", i, 16'(seen), 16'(s.seen));
                        chk("err_flag", i, 16'(err), 16'(s.err));
                        chk("scan_lost", i, 16'(lost), 16'(s.lost));
                        chk("frame_word", i, word, s.word);
                    end
                    if (valid) begin
                        fv_count[i]++;
                        if (fr_q[i].size() == 0) begin
                            chk("unexpected_frame", i, 16'(valid), 16'h0);
                        end else begin
                            f = fr_q[i].pop_front();
                            chk("frame_cycle", i, 16'(cyc), 16'(f.tag));
                            chk("frame_value", i, word, f.word);
                        end
                    end else if (fr_q[i].size() > 0 && fr_q[i][0].tag <= cyc) begin
                        f = fr_q[i].pop_front();
                        chk("missing_frame", i, 16'(valid), 16'h1);
                    end
                end
            end
        end
    end

    initial begin
        int fa, fb, hold, kind, d;
        logic [3:0] sel, val, low_bit;
        logic [3:0] bad_pats [8] = '{4'b0000, 4'b1100, 4'b1010, 4'b0101,
                                      4'b0011, 4'b1000, 4'b0001, 4'b0110};
        set_pins(4'hF, 4'h0, 1'b0);
        model_reset();
        @(negedge clk);
        do_reset(3);

        // Basic frame, one cycle per digit.
        fa = fv_count[0];
        drive(4'b1110, 4'h4, 0); drive(4'b1101, 4'h3, 0);
        drive(4'b1011, 4'h2, 0); drive(4'b0111, 4'h1, 0);
        blanks(3);
        chk("basic_word", 0, bus_a.frame_word, 16'h1234);
        chk("basic_pulses", 0, 16'(fv_count[0] - fa), 16'd1);

        // Blanks interleaved between digits.
        fa = fv_count[0];
        drive(4'b1110, 4'h4, 0); blanks(1); drive(4'b1101, 4'h3, 0); blanks(2);
        drive(4'b1011, 4'h2, 0); blanks(1); drive(4'b0111, 4'h1, 0); blanks(3);
        chk("blank_word", 0, bus_a.frame_word, 16'h1234);
        chk("blank_pulses", 0, 16'(fv_count[0] - fa), 16'd1);
        chk("blank_err", 0, 16'(bus_a.err_flag), 16'h0);

        // Illegal pattern mid-frame, then clear.
        drive(4'b1110, 4'h9, 0); drive(4'b1101, 4'h8, 0);
        drive(4'b1100, 4'h0, 0); blanks(2);
        chk("illegal_err", 0, 16'(bus_a.err_flag), 16'h1);
        chk("illegal_seen", 0, 16'(bus_a.digit_seen), 16'h0);
        chk("illegal_word", 0, bus_a.frame_word, 16'h1234);
        drive(4'hF, 4'h0, 1); blanks(2);
        chk("cleared_err", 0, 16'(bus_a.err_flag), 16'h0);

        // Dwell: two cycles per digit is too short for dwell 3, three is enough.
        fb = fv_count[1];
        for (int k = 0; k < 4; k++) begin
            low_bit = 4'b0001 << k; sel = ~low_bit;
            repeat (2) drive(sel, 4'(5 + k), 0);
        end
        blanks(2);
        chk("dwell_short", 1, 16'(fv_count[1] - fb), 16'd0);
        for (int k = 0; k < 4; k++) begin
            low_bit = 4'b0001 << k; sel = ~low_bit;
            repeat (3) drive(sel, 4'(9 + k), 0);
        end
        blanks(3);
        chk("dwell_long", 1, 16'(fv_count[1] - fb), 16'd1);
        chk("dwell_word", 1, bus_b.frame_word, 16'hCBA9);

        // Timeout after two digits.
        drive(4'b1110, 4'h1, 0); drive(4'b1101, 4'h2, 0);
        blanks(16);
        chk("pre_timeout", 0, 16'(bus_a.scan_lost), 16'h0);
        blanks(1);
        chk("timeout_lost", 0, 16'(bus_a.scan_lost), 16'h1);
        chk("timeout_seen", 0, 16'(bus_a.digit_seen), 16'h0);
        drive(4'b1011, 4'h3, 0); blanks(1);
        chk("recover_lost", 0, 16'(bus_a.scan_lost), 16'h0);
        chk("recover_seen", 0, 16'(bus_a.digit_seen), 16'b0100);

        // Reset mid-frame discards partial captures.
        drive(4'b1110, 4'h1, 0); drive(4'b1101, 4'h2, 0); drive(4'b1011, 4'h3, 0);
        do_reset(2);
        fa = fv_count[0];
        drive(4'b0111, 4'h7, 0); blanks(2);
        chk("post_reset_seen", 0, 16'(bus_a.digit_seen), 16'b1000);
        chk("post_reset_word", 0, bus_a.frame_word, 16'h0);
        chk("post_reset_pulses", 0, 16'(fv_count[0] - fa), 16'd0);

        // Randomized scan traffic.
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 99);
            hold = $urandom_range(1, 4);
            if (kind < 75) begin
                d = $urandom_range(0, 3);
                low_bit = 4'b0001 << d; sel = ~low_bit;
                val = 4'($urandom_range(0, 15));
            end else if (kind < 92) begin
                sel = 4'hF; val = 4'h0;
                if (kind > 89) hold = $urandom_range(10, 20);
            end else begin
                sel = bad_pats[$urandom_range(0, 7)]; val = 4'h0;
                hold = 1;
            end
            repeat (hold) drive(sel, val, ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
        end
        blanks(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_capture.md
DISPLAY_CAPTURE -- requirements
Module: display_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 1: consecutive sampled cycles a digit pattern must hold before acceptance (1..15).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: cycles without an accepted digit before scan is declared lost (2..65535).
REQ-003 Port clk, input, 1: sole clock, all state on rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port digit_select, input, 4: active-low one-hot digit enable from the display scan bus.
REQ-006 Port digit_value, input, 4: nibble value accompanying digit_select.
REQ-007 Port err_clear, input, 1: synchronous clear of err_flag.
REQ-008 Port frame_word, output, 16: last complete reconstructed display word.
REQ-009 Port frame_valid, output, 1: one-cycle pulse when frame_word updates.
REQ-010 Port digit_seen, output, 4: digits captured in the current frame-in-progress.
REQ-011 Port err_flag, output, 1: sticky illegal-pattern indicator.
REQ-012 Port scan_lost, output, 1: level, high while scan timeout is active.
REQ-013 Clocking and reset SHALL be: one clock; reset is asynchronous and active-high.

Function
REQ-014 digit_select and digit_value SHALL be registered once (sample stage) before any decision.
REQ-015 Pattern mapping SHALL be: 1110 -> digit 0 -> bits [3:0]; 1101 -> digit 1 -> [7:4]; 1011 -> digit 2 -> [11:8]; 0111 -> digit 3 -> [15:12].
REQ-016 Pattern 1111 (blank) SHALL be ignored: no capture, no error, dwell count reset to 0, timeout keeps counting.
REQ-017 Any other pattern (zero or multiple lows) SHALL set err_flag, clear digit_seen, and reset the dwell count.
REQ-018 Dwell count SHALL increment (saturating at 15) while the sampled pattern is unchanged and reset to 1 on any change; a digit SHALL be accepted exactly once, on the edge where the count reaches STABLE_CYCLES.
REQ-019 The value captured at acceptance SHALL be the sampled digit_value at that edge; a value change during the dwell SHALL restart the dwell count.
REQ-020 Acceptance SHALL write the nibble into a per-digit shadow register and set the matching digit_seen bit; re-acceptance of an already-seen digit overwrites its nibble, no error.
REQ-021 When an acceptance makes digit_seen all-ones, on that same edge frame_word SHALL load all four shadow nibbles (including the new one), frame_valid SHALL pulse for one cycle, and digit_seen SHALL clear to 0000.
REQ-022 Latency with STABLE_CYCLES=1: frame_valid high 2 clock edges after the completing digit appears on the pins.
REQ-023 Timeout counter SHALL reset on every acceptance and increment otherwise; on reaching TIMEOUT_CYCLES it SHALL set scan_lost, clear digit_seen, and hold (no wrap).
REQ-024 scan_lost SHALL clear on the next acceptance.
REQ-025 err_flag SHALL clear only on err_clear; an illegal pattern on the same edge as err_clear SHALL leave err_flag set.
REQ-026 Illegal pattern and timeout on the same edge: both effects apply; digit_seen ends 0000.
REQ-027 frame_word SHALL hold its value between frames, through errors and timeouts.

Reset
REQ-028 While reset is high: frame_word=0, frame_valid=0, digit_seen=0, err_flag=0, scan_lost=0, shadows, sample stage (to 1111), dwell and timeout counters=0.
REQ-029 Reset mid-frame SHALL discard partial captures; the first frame after release requires all four digits anew.

Structure
REQ-030 Shared package display_pkg SHALL hold the four digit anode patterns, the blank pattern, and the STABLE_CYCLES/TIMEOUT_CYCLES defaults.
REQ-031 One sub-module, dwell_filter (sample register plus dwell counter, emits accept pulse and decoded index), SHALL be instantiated; all frame logic stays in display_capture.

Verification
REQ-032 Drive 1110/4, 1101/3, 1011/2, 0111/1 one cycle each, STABLE_CYCLES=1 -> frame_valid one pulse, frame_word=16'h1234, 2 edges after last digit.
REQ-033 Same sequence with 1111 inserted between digits -> identical frame_word=16'h1234, no err_flag.
REQ-034 Drive 1100 after two digits -> err_flag=1, digit_seen=0000, frame_word unchanged; err_clear -> err_flag=0.
REQ-035 STABLE_CYCLES=3, each digit held 2 cycles -> no frame_valid; held 3 cycles -> frame_valid, word correct.
REQ-036 TIMEOUT_CYCLES=16, stop after two digits -> scan_lost=1 at cycle 16 after last accept, digit_seen=0000; next valid digit -> scan_lost=0.
REQ-037 Assert reset after three digits, release, send one digit -> no frame_valid, digit_seen has one bit set, all outputs reset while reset high.
